// File: rtl/icmp_echo_rx.sv
// icmp_echo_rx: GMII ICMP echo-request parser; optional IP header checksum check under `IP_CSUM_CHECK_EN
module icmp_echo_rx #(
  parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
  parameter logic [31:0] BOARD_IP = {8'd192, 8'd168, 8'd1, 8'd10},
  parameter int MAX_DATA_BYTES = 1472
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        gmii_rx_dv,
  input  logic [7:0]  gmii_rxd,
  output logic        rec_en,
  output logic [7:0]  rec_data,
  output logic        rec_pkt_done,
  output logic [15:0] rec_byte_num,
  output logic [15:0] icmp_id,
  output logic [15:0] icmp_seq,
  output logic [31:0] reply_checksum,
  output logic        rec_err
);
  typedef enum logic [2:0] {IDLE, PREAMBLE, ETH_HEAD, IP_HEAD, ICMP_HEAD, RX_DATA, RX_END} state_t;
  state_t state, state_nxt, adv;
  logic armed, ver_ok, proto_ok, icmp_ok, fail, last, pass, csum_ok;
  logic [15:0] cnt, total_len, data_len, hdr_len, len_calc;
  logic [23:0] sh;
  logic [47:0] mac;
  logic [3:0] ihl;
  logic [31:0] dst_ip, dst_now;
  logic [7:0] hi;
  assign hdr_len = ver_ok ? {10'd0, ihl, 2'b00} : 16'd20;
  assign len_calc = total_len - hdr_len - 16'd8;
  assign dst_now = (cnt == 16'd19) ? {sh, gmii_rxd} : dst_ip;
`ifdef IP_CSUM_CHECK_EN
  logic [15:0] csum, csum_fold;
  logic [16:0] csum_add;
  assign csum_add = {1'b0, csum} + {1'b0, sh[7:0], gmii_rxd};
  assign csum_fold = csum_add[15:0] + {15'd0, csum_add[16]};
  assign csum_ok = csum_fold == 16'hffff;
  // ones-complement header sum, one word per odd header byte, idle outside the IP header
  always_ff @(posedge clk)
    if (rst || state != IP_HEAD) csum <= '0;
    else if (cnt[0]) csum <= csum_fold;
`else
  assign csum_ok = 1'b1;
`endif
  // state register
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  // per-state byte checks and next state; any early dv drop or failed check ends in RX_END
  always_comb begin
    state_nxt = state;
    adv = state;
    last = 1'b0;
    pass = 1'b1;
    fail = 1'b0;
    case (state)
      IDLE: state_nxt = (armed && gmii_rx_dv && gmii_rxd == 8'h55) ? PREAMBLE : IDLE;
      PREAMBLE: begin
        last = cnt == 16'd7;
        pass = last ? gmii_rxd == 8'hd5 : gmii_rxd == 8'h55;
        adv = ETH_HEAD;
      end
      ETH_HEAD: begin
        last = cnt == 16'd13;
        pass = !last || ((mac == BOARD_MAC || &mac) && {sh[7:0], gmii_rxd} == 16'h0800);
        adv = IP_HEAD;
      end
      IP_HEAD: begin
        last = cnt == hdr_len - 16'd1;
        pass = !last || (ver_ok && proto_ok && dst_now == BOARD_IP && csum_ok);
        adv = ICMP_HEAD;
      end
      ICMP_HEAD: begin
        last = cnt == 16'd7;
        pass = !last || (icmp_ok && total_len >= hdr_len + 16'd8 && len_calc <= 16'(MAX_DATA_BYTES));
        adv = (len_calc == 16'd0) ? RX_END : RX_DATA;
      end
      RX_DATA: begin
        last = cnt == data_len - 16'd1;
        adv = RX_END;
      end
      RX_END: state_nxt = gmii_rx_dv ? RX_END : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (state != IDLE && state != RX_END) begin
      fail = !gmii_rx_dv || !pass;
      state_nxt = fail ? RX_END : last ? adv : state;
    end
  end
  // field capture, payload streaming and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      armed <= 1'b0;
      cnt <= '0;
      sh <= '0;
      mac <= '0;
      ihl <= '0;
      ver_ok <= 1'b0;
      total_len <= '0;
      proto_ok <= 1'b0;
      dst_ip <= '0;
      icmp_ok <= 1'b0;
      data_len <= '0;
      hi <= '0;
      rec_en <= 1'b0;
      rec_data <= '0;
      rec_pkt_done <= 1'b0;
      rec_byte_num <= '0;
      icmp_id <= '0;
      icmp_seq <= '0;
      reply_checksum <= '0;
      rec_err <= 1'b0;
    end else begin
      armed <= armed | ~gmii_rx_dv;
      cnt <= (state == IDLE) ? 16'd1 : (state_nxt != state) ? 16'd0 : cnt + 16'd1;
      sh <= {sh[15:0], gmii_rxd};
      rec_en <= 1'b0;
      rec_pkt_done <= 1'b0;
      rec_err <= fail;
      if (state == ETH_HEAD && cnt < 16'd6) mac <= {mac[39:0], gmii_rxd};
      if (state == IP_HEAD && cnt == 16'd0) begin
        ihl <= gmii_rxd[3:0];
        ver_ok <= gmii_rxd[7:4] == 4'd4 && gmii_rxd[3:0] >= 4'd5;
      end
      if (state == IP_HEAD && cnt == 16'd3) total_len <= {sh[7:0], gmii_rxd};
      if (state == IP_HEAD && cnt == 16'd9) proto_ok <= gmii_rxd == 8'd1;
      if (state == IP_HEAD && cnt == 16'd19) dst_ip <= dst_now;
      if (state == ICMP_HEAD && cnt == 16'd0) icmp_ok <= gmii_rxd == 8'd8;
      if (state == ICMP_HEAD && cnt == 16'd1) icmp_ok <= icmp_ok && gmii_rxd == 8'd0;
      if (state == ICMP_HEAD && last && !fail) begin
        icmp_id <= sh[23:8];
        icmp_seq <= {sh[7:0], gmii_rxd};
        rec_byte_num <= len_calc;
        data_len <= len_calc;
        reply_checksum <= '0;
        rec_pkt_done <= len_calc == 16'd0;
      end
      if (state == RX_DATA && !fail) begin
        rec_en <= 1'b1;
        rec_data <= gmii_rxd;
        hi <= gmii_rxd;
        rec_pkt_done <= last;
        reply_checksum <= reply_checksum + (cnt[0] ? {16'd0, hi, gmii_rxd} : last ? {16'd0, gmii_rxd, 8'h00} : 32'd0);
      end
    end
  end
endmodule

// File: tb/tb_icmp_echo_rx.sv
// tb_icmp_echo_rx: table-driven and randomized frame checks against a frame-level reference model
module tb_icmp_echo_rx;
  localparam logic [47:0] MAC = 48'h00_11_22_33_44_55;
  typedef struct {
    int mac_sel;
    int ihl;
    int plen;
    int tl_extra;
    logic [7:0] typ;
    logic [7:0] ip_last;
    int cut;
    logic bad_csum;
    logic [15:0] id;
    logic [15:0] seq;
    logic [7:0] pbase;
    logic [7:0] pstep;
    logic exp_hdr;
    logic exp_ok;
    int exp_en;
    logic [31:0] exp_sum;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1, dv = 1'b0;
  logic [7:0] rxd = '0;
  logic rec_en, rec_pkt_done, rec_err;
  logic [7:0] rec_data;
  logic [15:0] rec_byte_num, icmp_id, icmp_seq;
  logic [31:0] reply_checksum;
  int vectors = 0, miscompares = 0, n_done = 0, n_err = 0;
  logic [31:0] done_sum = '0;
  logic [7:0] got[$];
  logic [7:0] frm[$];
  logic [15:0] e_len = '0, e_id = '0, e_seq = '0;
  vec_t tbl[14];
  always #5 clk = ~clk;
  icmp_echo_rx dut (
    .clk(clk), .rst(rst), .gmii_rx_dv(dv), .gmii_rxd(rxd),
    .rec_en(rec_en), .rec_data(rec_data), .rec_pkt_done(rec_pkt_done),
    .rec_byte_num(rec_byte_num), .icmp_id(icmp_id), .icmp_seq(icmp_seq),
    .reply_checksum(reply_checksum), .rec_err(rec_err)
  );
  always @(negedge clk) begin
    if (rec_en) got.push_back(rec_data);
    if (rec_pkt_done) begin
      n_done++;
      done_sum = reply_checksum;
    end
    if (rec_err) n_err++;
  end
  task automatic chk(input string name, input logic [63:0] a, input logic [63:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, a, e);
    end
  endtask
  task automatic put(input logic v, input logic [7:0] d);
    @(posedge clk);
    #1;
    dv = v;
    rxd = d;
  endtask
  function automatic logic [7:0] pb(input vec_t v, input int i);
    return v.pbase + v.pstep * 8'(i);
  endfunction
  function automatic vec_t model(input vec_t v);
    int hl, decl, avail;
    logic hp;
    hl = 30 + 4 * v.ihl;
    decl = v.plen + v.tl_extra;
    hp = v.mac_sel != 2 && v.ip_last == 8'd10 && v.typ == 8'd8 && decl >= 0 && decl <= 1472 && (v.cut < 0 || v.cut >= hl);
`ifdef IP_CSUM_CHECK_EN
    hp = hp && !v.bad_csum;
`endif
    avail = (v.cut < 0) ? v.plen : v.cut - hl;
    v.exp_hdr = hp;
    v.exp_en = hp ? ((avail < v.plen) ? avail : v.plen) : 0;
    v.exp_ok = hp && avail >= v.plen;
    v.exp_sum = '0;
    for (int i = 0; i < v.plen; i += 2)
      v.exp_sum += {16'd0, pb(v, i), (i + 1 < v.plen) ? pb(v, i + 1) : 8'h00};
    return v;
  endfunction
  task automatic build(input vec_t v);
    logic [7:0] h[0:59];
    logic [47:0] dm;
    logic [31:0] s;
    logic [15:0] tl, ck;
    int hl;
    frm.delete();
    repeat (7) frm.push_back(8'h55);
    frm.push_back(8'hd5);
    dm = (v.mac_sel == 1) ? '1 : (v.mac_sel == 2) ? 48'h00_11_22_33_44_56 : MAC;
    for (int i = 0; i < 6; i++) frm.push_back(dm[47 - 8 * i -: 8]);
    for (int i = 0; i < 6; i++) frm.push_back(8'h02 + 8'(i));
    frm.push_back(8'h08);
    frm.push_back(8'h00);
    hl = v.ihl * 4;
    tl = 16'(hl + 8 + v.plen + v.tl_extra);
    for (int i = 0; i < 60; i++) h[i] = 8'h01;
    h[0] = {4'h4, 4'(v.ihl)}; h[1] = 8'h00; h[2] = tl[15:8]; h[3] = tl[7:0];
    h[4] = 8'h12; h[5] = 8'h34; h[6] = 8'h40; h[7] = 8'h00; h[8] = 8'd64; h[9] = 8'd1;
    h[10] = 8'h00; h[11] = 8'h00; h[12] = 8'd192; h[13] = 8'd168; h[14] = 8'd1; h[15] = 8'd2;
    h[16] = 8'd192; h[17] = 8'd168; h[18] = 8'd1; h[19] = v.ip_last;
    s = '0;
    for (int i = 0; i < hl; i += 2) s += {16'd0, h[i], h[i + 1]};
    s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
    s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
    ck = ~s[15:0] + {15'd0, v.bad_csum};
    h[10] = ck[15:8];
    h[11] = ck[7:0];
    for (int i = 0; i < hl; i++) frm.push_back(h[i]);
    frm.push_back(v.typ);
    repeat (3) frm.push_back(8'h00);
    frm.push_back(v.id[15:8]);
    frm.push_back(v.id[7:0]);
    frm.push_back(v.seq[15:8]);
    frm.push_back(v.seq[7:0]);
    for (int i = 0; i < v.plen; i++) frm.push_back(pb(v, i));
    frm.push_back(8'hc3); frm.push_back(8'h5a); frm.push_back(8'h96); frm.push_back(8'h0f);
    if (v.cut >= 0) while (frm.size() > v.cut) void'(frm.pop_back());
  endtask
  task automatic check(input vec_t v, input string name, input int en0, input int d0, input int r0);
    int bad;
    bad = 0;
    chk({name, ".en_count"}, 64'(got.size() - en0), 64'(v.exp_en));
    for (int i = 0; i < v.exp_en && en0 + i < got.size(); i++)
      if (got[en0 + i] !== pb(v, i)) bad++;
    chk({name, ".payload_bad_bytes"}, 64'(bad), 64'd0);
    chk({name, ".done_pulses"}, 64'(n_done - d0), 64'(v.exp_ok));
    chk({name, ".err_pulses"}, 64'(n_err - r0), 64'(!v.exp_ok));
    if (v.exp_hdr) begin
      e_len = 16'(v.plen + v.tl_extra);
      e_id = v.id;
      e_seq = v.seq;
    end
    chk({name, ".byte_num"}, 64'(rec_byte_num), 64'(e_len));
    chk({name, ".id_seq"}, {32'd0, icmp_id, icmp_seq}, {32'd0, e_id, e_seq});
    if (v.exp_ok) chk({name, ".checksum"}, 64'(done_sum), 64'(v.exp_sum));
  endtask
  task automatic run(input vec_t v, input string name);
    int en0, d0, r0;
    en0 = got.size();
    d0 = n_done;
    r0 = n_err;
    build(v);
    foreach (frm[i]) put(1'b1, frm[i]);
    repeat (4) put(1'b0, 8'h00);
    check(v, name, en0, d0, r0);
  endtask
  initial begin
    vec_t v, w;
    int en0, d0, r0;
    tbl[0]  = '{0, 5, 32, 0, 8'h08, 8'd10, -1, 1'b0, 16'h0001, 16'h0022, 8'h00, 8'h01, 1'b1, 1'b1, 32, 32'h0000f100};
    tbl[1]  = '{1, 6, 3, 0, 8'h08, 8'd10, -1, 1'b0, 16'h1234, 16'h5678, 8'haa, 8'h11, 1'b1, 1'b1, 3, 32'h000176bb};
    tbl[2]  = '{0, 5, 8, 0, 8'h08, 8'd11, -1, 1'b0, 16'h9999, 16'h9999, 8'h00, 8'h01, 1'b0, 1'b0, 0, 32'h0};
    tbl[3]  = '{0, 5, 1, 0, 8'h08, 8'd10, -1, 1'b0, 16'h00ab, 16'h0001, 8'h7e, 8'h00, 1'b1, 1'b1, 1, 32'h00007e00};
    tbl[4]  = '{0, 5, 0, 1473, 8'h08, 8'd10, -1, 1'b0, 16'h4444, 16'h4444, 8'h00, 8'h01, 1'b0, 1'b0, 0, 32'h0};
    tbl[5]  = '{0, 5, 4, 0, 8'h00, 8'd10, -1, 1'b0, 16'h5555, 16'h5555, 8'h00, 8'h01, 1'b0, 1'b0, 0, 32'h0};
    tbl[6]  = '{0, 5, 32, 0, 8'h08, 8'd10, 60, 1'b0, 16'h0007, 16'h0008, 8'h00, 8'h01, 1'b1, 1'b0, 10, 32'h0};
    tbl[7]  = '{0, 5, 0, 0, 8'h08, 8'd10, -1, 1'b0, 16'h0abc, 16'h0def, 8'h00, 8'h00, 1'b1, 1'b1, 0, 32'h0};
    tbl[8]  = '{1, 5, 1472, 0, 8'h08, 8'd10, -1, 1'b0, 16'hbeef, 16'h0100, 8'h01, 8'h00, 1'b1, 1'b1, 1472, 32'h0002e2e0};
    tbl[9]  = '{2, 5, 4, 0, 8'h08, 8'd10, -1, 1'b0, 16'h6666, 16'h6666, 8'h00, 8'h01, 1'b0, 1'b0, 0, 32'h0};
    tbl[10] = '{0, 5, 4, 0, 8'h08, 8'd10, 30, 1'b0, 16'h7777, 16'h7777, 8'h00, 8'h01, 1'b0, 1'b0, 0, 32'h0};
`ifdef IP_CSUM_CHECK_EN
    tbl[11] = '{0, 5, 4, 0, 8'h08, 8'd10, -1, 1'b1, 16'h0c5c, 16'h0001, 8'h10, 8'h10, 1'b0, 1'b0, 0, 32'h0};
`else
    tbl[11] = '{0, 5, 4, 0, 8'h08, 8'd10, -1, 1'b1, 16'h0c5c, 16'h0001, 8'h10, 8'h10, 1'b1, 1'b1, 4, 32'h00004060};
`endif
    tbl[12] = '{0, 15, 2, 0, 8'h08, 8'd10, -1, 1'b0, 16'h0f0f, 16'hf0f0, 8'h12, 8'h22, 1'b1, 1'b1, 2, 32'h00001234};
    tbl[13] = '{0, 5, 0, -4, 8'h08, 8'd10, -1, 1'b0, 16'h8888, 16'h8888, 8'h00, 8'h01, 1'b0, 1'b0, 0, 32'h0};
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset.ctrl", {51'd0, rec_en, rec_pkt_done, rec_err, rec_data, 2'b0}, 64'd0);
    chk("reset.values", {icmp_id, icmp_seq, reply_checksum}, 64'd0);
    chk("reset.byte_num", 64'(rec_byte_num), 64'd0);
    for (int i = 0; i < 14; i++) run(tbl[i], $sformatf("tbl%0d", i));
    en0 = got.size();
    d0 = n_done;
    r0 = n_err;
    build(tbl[3]);
    foreach (frm[i]) put(1'b1, frm[i]);
    put(1'b0, 8'h00);
    build(tbl[1]);
    foreach (frm[i]) put(1'b1, frm[i]);
    repeat (4) put(1'b0, 8'h00);
    chk("b2b.done_pulses", 64'(n_done - d0), 64'd2);
    chk("b2b.err_pulses", 64'(n_err - r0), 64'd0);
    chk("b2b.en_count", 64'(got.size() - en0), 64'd4);
    chk("b2b.id_seq", {32'd0, icmp_id, icmp_seq}, {32'd0, tbl[1].id, tbl[1].seq});
    chk("b2b.checksum", 64'(done_sum), 64'h176bb);
    e_len = 16'd3;
    e_id = tbl[1].id;
    e_seq = tbl[1].seq;
    en0 = got.size();
    d0 = n_done;
    r0 = n_err;
    build(tbl[0]);
    for (int i = 0; i < 30; i++) put(1'b1, frm[i]);
    @(posedge clk);
    #1 rst = 1'b1;
    rxd = frm[30];
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 31; i < frm.size(); i++) put(1'b1, frm[i]);
    foreach (frm[i]) put(1'b1, frm[i]);
    @(negedge clk);
    chk("midrst.values", {icmp_id, icmp_seq, reply_checksum}, 64'd0);
    chk("midrst.byte_num", 64'(rec_byte_num), 64'd0);
    chk("midrst.no_activity", {32'(n_done - d0), 32'(got.size() - en0)}, 64'd0);
    chk("midrst.err_pulses", 64'(n_err - r0), 64'd0);
    e_len = '0;
    e_id = '0;
    e_seq = '0;
    repeat (2) put(1'b0, 8'h00);
    run(tbl[0], "after_rst");
    for (int n = 0; n < 40; n++) begin
      v.mac_sel = ($urandom_range(0, 9) == 0) ? 2 : int'($urandom_range(0, 1));
      v.ihl = $urandom_range(5, 8);
      v.plen = $urandom_range(0, 40);
      v.tl_extra = 0;
      v.typ = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'h08;
      v.ip_last = ($urandom_range(0, 7) == 0) ? 8'd11 : 8'd10;
      v.cut = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 34 + 4 * v.ihl + v.plen)) : -1;
      v.bad_csum = ($urandom_range(0, 5) == 0);
      v.id = 16'($urandom);
      v.seq = 16'($urandom);
      v.pbase = 8'($urandom);
      v.pstep = 8'($urandom);
      w = model(v);
      run(w, $sformatf("rand%0d", n));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
